// File: rtl/stream_pack_pkg.sv
// stream_pack_pkg: shared byte/entry types, popcount and exclusive prefix-sum helpers, default buffer sizing
package stream_pack_pkg;
  localparam int N_IN_DEF = 4;
  localparam int N_OUT_DEF = 4;
  localparam int BUF = N_IN_DEF + N_OUT_DEF;
  localparam int CNT_W = $clog2(BUF + 1);
  typedef logic [7:0] byte_t;
  typedef struct packed {
    logic  last;
    byte_t data;
  } entry_t;
  function automatic int popcount(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction
  function automatic int prefix_sum(input logic [31:0] v, input int i);
    int n = 0;
    for (int j = 0; j < 32; j++) if (j < i) n += int'(v[j]);
    return n;
  endfunction
endpackage

// File: rtl/axis_unpack_scatter.sv
// axis_unpack_scatter: scatter oldest buffer bytes into masked lanes (mask, win in; data, any_last, final_last out)
module axis_unpack_scatter
  import stream_pack_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF
) (
  input  logic [N_OUT-1:0]             mask,
  input  entry_t [N_OUT-1:0]           win,
  output logic [N_OUT*8-1:0]           data,
  output logic                         any_last,
  output logic                         final_last
);
  localparam int KW = N_OUT > 1 ? $clog2(N_OUT) : 1;
  logic [KW-1:0] k;
  always_comb begin
    data = '0;
    any_last = 1'b0;
    final_last = 1'b0;
    k = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (mask[i]) begin
        k = KW'(prefix_sum(32'(mask), i));
        data[i*8+:8] = win[k].data;
        any_last = any_last | win[k].last;
        final_last = win[k].last;
      end
    end
  end
endmodule

// File: rtl/stream_unpacker.sv
// stream_unpacker: packed stream + lane mask -> sparse stream (packed_*/mask_* in, sparse_* out, sticky err, clk/rst_n)
module stream_unpacker
  import stream_pack_pkg::*;
#(
  parameter int N_BYTES_IN  = N_IN_DEF,
  parameter int N_BYTES_OUT = N_OUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_BYTES_IN*8-1:0]    packed_tdata,
  input  logic [N_BYTES_IN-1:0]      packed_tkeep,
  input  logic                       packed_tlast,
  input  logic                       packed_tvalid,
  output logic                       packed_tready,
  input  logic [N_BYTES_OUT-1:0]     mask_tkeep,
  input  logic                       mask_tlast,
  input  logic                       mask_tvalid,
  output logic                       mask_tready,
  output logic [N_BYTES_OUT*8-1:0]   sparse_tdata,
  output logic [N_BYTES_OUT-1:0]     sparse_tkeep,
  output logic                       sparse_tlast,
  output logic                       sparse_tvalid,
  input  logic                       sparse_tready,
  output logic                       err
);
  localparam int B = N_BYTES_IN + N_BYTES_OUT;
  localparam int CW = $clog2(B + 1);
  localparam int IW = $clog2(B);
  entry_t [B-1:0] buf_q, buf_d;
  logic [CW-1:0] count, count_d, p, pushed, pp, base;
  logic push, pop, out_free, any_last, final_last;
  logic [N_BYTES_OUT*8-1:0] scat;
  assign p = CW'(popcount(32'(mask_tkeep)));
  assign pushed = CW'(popcount(32'(packed_tkeep)));
  assign out_free = !sparse_tvalid || sparse_tready;
  assign pop = rst_n && mask_tvalid && count >= p && out_free;
  assign mask_tready = pop;
  assign packed_tready = rst_n && count <= CW'(N_BYTES_OUT);
  assign push = packed_tvalid && packed_tready;
  assign pp = pop ? p : '0;
  assign base = count - pp;
  assign count_d = base + (push ? pushed : '0);
  always_comb begin
    buf_d = '0;
    for (int j = 0; j < B; j++) buf_d[j] = (j + int'(pp) < B) ? buf_q[IW'(j + int'(pp))] : '0;
    for (int j = 0; j < N_BYTES_IN; j++)
      if (push && packed_tkeep[j] && int'(base) + j < B)
        buf_d[IW'(int'(base) + j)] = {packed_tlast && (j == int'(pushed) - 1), packed_tdata[j*8+:8]};
  end
  axis_unpack_scatter #(.N_OUT(N_BYTES_OUT)) u_scatter (
    .mask       (mask_tkeep),
    .win        (buf_q[N_BYTES_OUT-1:0]),
    .data       (scat),
    .any_last   (any_last),
    .final_last (final_last)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      count <= '0;
      sparse_tdata <= '0;
      sparse_tkeep <= '0;
      sparse_tlast <= 1'b0;
      sparse_tvalid <= 1'b0;
      err <= 1'b0;
    end else begin
      buf_q <= buf_d;
      count <= count_d;
      if (pop) begin
        sparse_tdata <= scat;
        sparse_tkeep <= mask_tkeep;
        sparse_tlast <= mask_tlast;
        sparse_tvalid <= 1'b1;
        err <= err | (!mask_tlast && any_last) | (mask_tlast && p != '0 && !final_last);
      end else if (sparse_tready) sparse_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_unpacker.sv
// tb_stream_unpacker: table vectors, corner sequences and randomized streams checked against a byte-queue model
module tb_stream_unpacker;
  import stream_pack_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] packed_tdata = '0;
  logic [3:0] packed_tkeep = '0;
  logic packed_tlast = 1'b0, packed_tvalid = 1'b0, packed_tready;
  logic [3:0] mask_tkeep = '0;
  logic mask_tlast = 1'b0, mask_tvalid = 1'b0, mask_tready;
  logic [31:0] sparse_tdata;
  logic [3:0] sparse_tkeep;
  logic sparse_tlast, sparse_tvalid, err;
  logic sparse_tready = 1'b0;
  always #5 clk = ~clk;
  stream_unpacker #(.N_BYTES_IN(4), .N_BYTES_OUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .packed_tdata  (packed_tdata),
    .packed_tkeep  (packed_tkeep),
    .packed_tlast  (packed_tlast),
    .packed_tvalid (packed_tvalid),
    .packed_tready (packed_tready),
    .mask_tkeep    (mask_tkeep),
    .mask_tlast    (mask_tlast),
    .mask_tvalid   (mask_tvalid),
    .mask_tready   (mask_tready),
    .sparse_tdata  (sparse_tdata),
    .sparse_tkeep  (sparse_tkeep),
    .sparse_tlast  (sparse_tlast),
    .sparse_tvalid (sparse_tvalid),
    .sparse_tready (sparse_tready),
    .err           (err)
  );
  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;
  typedef struct {
    logic        do_push;
    logic [31:0] pd;
    logic [3:0]  pk;
    logic        pl;
    logic [3:0]  mk;
    logic        ml;
    logic [31:0] ed;
    logic        ee;
  } vec_t;
  int n_vec = 0;
  int n_bad = 0;
  beat_t pq[$], mq[$], eq[$];
  vec_t tbl[7];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tmo(input string nm, input int n, input int lim);
    n_vec++;
    if (n >= lim) begin
      n_bad++;
      $display("FAIL %s: waited %0d cycles, limit %0d", nm, n, lim);
    end
  endtask
  task automatic push_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n = 0;
    packed_tdata = d;
    packed_tkeep = k;
    packed_tlast = l;
    packed_tvalid = 1'b1;
    #1;
    while (!packed_tready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    tmo("push_wait", n, 50);
    @(negedge clk);
    packed_tvalid = 1'b0;
  endtask
  task automatic send_mask(input logic [3:0] k, input logic l);
    int n = 0;
    mask_tkeep = k;
    mask_tlast = l;
    mask_tvalid = 1'b1;
    #1;
    while (!mask_tready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    tmo("mask_wait", n, 50);
    @(negedge clk);
    mask_tvalid = 1'b0;
  endtask
  task automatic gen(input int np, input bit full);
    beat_t b;
    int len, r, n;
    logic [3:0] m;
    for (int q = 0; q < np; q++) begin
      len = full ? 4 * int'($urandom_range(3, 1)) : int'($urandom_range(12, 1));
      r = len;
      while (r > 0) begin
        n = r > 4 ? 4 : r;
        b.d = $urandom;
        b.k = 4'((1 << n) - 1);
        b.l = (r == n);
        pq.push_back(b);
        r -= n;
      end
      r = len;
      while (r > 0) begin
        m = full ? 4'hF : 4'($urandom_range(15));
        while ($countones(m) > r) m = m & (m - 4'd1);
        r -= $countones(m);
        b.d = '0;
        b.k = m;
        b.l = (r == 0);
        mq.push_back(b);
      end
    end
  endtask
  task automatic run(input int hm, input int hs, input int pv, input int mv, input int sr, input bit fchk, input bit tchk);
    logic [8:0] bq[$];
    logic [8:0] e;
    beat_t b;
    int pi = 0, mi = 0, oi = 0, first = -1, lastc = 0;
    logic stall = 1'b0, ee = 1'b0, any, fin;
    logic [37:0] prev = '0;
    eq.delete();
    foreach (pq[x])
      for (int j = 0; j < 4; j++)
        if (pq[x].k[j]) bq.push_back({pq[x].l && j == $countones(pq[x].k) - 1, pq[x].d[j*8+:8]});
    foreach (mq[x]) begin
      b.d = '0;
      b.k = mq[x].k;
      b.l = mq[x].l;
      any = 1'b0;
      fin = 1'b0;
      for (int i = 0; i < 4; i++)
        if (b.k[i]) begin
          e = bq.pop_front();
          b.d[i*8+:8] = e[7:0];
          any |= e[8];
          fin = e[8];
        end
      ee |= (!b.l && any) || (b.l && b.k != 0 && !fin);
      eq.push_back(b);
    end
    for (int c = 0; c < 4000 && oi < eq.size(); c++) begin
      @(negedge clk);
      if (stall) chk("stable", 64'({sparse_tvalid, sparse_tlast, sparse_tkeep, sparse_tdata}), 64'(prev));
      packed_tvalid = pi < pq.size() && int'($urandom_range(99)) < pv;
      if (pi < pq.size()) begin
        packed_tdata = pq[pi].d;
        packed_tkeep = pq[pi].k;
        packed_tlast = pq[pi].l;
      end
      mask_tvalid = c >= hm && mi < mq.size() && int'($urandom_range(99)) < mv;
      if (mi < mq.size()) begin
        mask_tkeep = mq[mi].k;
        mask_tlast = mq[mi].l;
      end
      sparse_tready = c >= hs && int'($urandom_range(99)) < sr;
      #1;
      if (fchk && c == 5) chk("full_tready", 64'(packed_tready), 64'(0));
      if (packed_tvalid && packed_tready) pi++;
      if (mask_tvalid && mask_tready) mi++;
      if (sparse_tvalid && sparse_tready) begin
        chk("beat", 64'({sparse_tlast, sparse_tkeep, sparse_tdata}), 64'({eq[oi].l, eq[oi].k, eq[oi].d}));
        if (first < 0) first = c;
        lastc = c;
        oi++;
      end
      stall = sparse_tvalid && !sparse_tready;
      prev = {sparse_tvalid, sparse_tlast, sparse_tkeep, sparse_tdata};
    end
    chk("beats_out", 64'(oi), 64'(eq.size()));
    @(negedge clk);
    packed_tvalid = 1'b0;
    mask_tvalid = 1'b0;
    sparse_tready = 1'b1;
    chk("run_err", 64'(err), 64'(ee));
    if (tchk) begin
      chk("tput_first", 64'(first), 64'(2));
      chk("tput_span", 64'(lastc - first), 64'(eq.size() - 1));
    end
    pq.delete();
    mq.delete();
  endtask
  initial begin
    tbl[0] = '{1'b1, 32'h44332211, 4'hF, 1'b1, 4'b0101, 1'b0, 32'h00220011, 1'b0};
    tbl[1] = '{1'b0, 32'h0, 4'h0, 1'b0, 4'b0011, 1'b1, 32'h00004433, 1'b0};
    tbl[2] = '{1'b1, 32'hDDCCBBAA, 4'hF, 1'b1, 4'b0000, 1'b0, 32'h00000000, 1'b0};
    tbl[3] = '{1'b0, 32'h0, 4'h0, 1'b0, 4'b1111, 1'b1, 32'hDDCCBBAA, 1'b0};
    tbl[4] = '{1'b1, 32'h88776655, 4'hF, 1'b1, 4'b1010, 1'b0, 32'h66005500, 1'b0};
    tbl[5] = '{1'b0, 32'h0, 4'h0, 1'b0, 4'b1100, 1'b1, 32'h88770000, 1'b0};
    tbl[6] = '{1'b1, 32'h000000EE, 4'b0001, 1'b1, 4'b0100, 1'b1, 32'h00EE0000, 1'b0};
    mask_tvalid = 1'b1;
    sparse_tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tvalid", 64'(sparse_tvalid), 64'(0));
    chk("rst_out", 64'({sparse_tlast, sparse_tkeep, sparse_tdata}), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_ptready", 64'(packed_tready), 64'(0));
    chk("rst_mtready", 64'(mask_tready), 64'(0));
    @(negedge clk);
    mask_tvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    foreach (tbl[i]) begin
      if (tbl[i].do_push) push_beat(tbl[i].pd, tbl[i].pk, tbl[i].pl);
      send_mask(tbl[i].mk, tbl[i].ml);
      #1;
      chk("vec_tvalid", 64'(sparse_tvalid), 64'(1));
      chk("vec_data", 64'(sparse_tdata), 64'(tbl[i].ed));
      chk("vec_keep", 64'(sparse_tkeep), 64'(tbl[i].mk));
      chk("vec_last", 64'(sparse_tlast), 64'(tbl[i].ml));
      chk("vec_err", 64'(err), 64'(tbl[i].ee));
    end
    @(negedge clk);
    gen(3, 1'b1);
    run(6, 10, 100, 100, 100, 1'b1, 1'b0);
    gen(4, 1'b1);
    run(0, 0, 100, 100, 100, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      gen(15, 1'b0);
      run(0, 0, 70, 70, 70, 1'b0, 1'b0);
    end
    @(negedge clk);
    sparse_tready = 1'b0;
    push_beat(32'h00CCBBAA, 4'b0111, 1'b1);
    push_beat(32'h44332211, 4'hF, 1'b0);
    send_mask(4'hF, 1'b1);
    #1;
    chk("err_tvalid", 64'(sparse_tvalid), 64'(1));
    chk("err_data", 64'(sparse_tdata), 64'(32'h11CCBBAA));
    chk("err_set", 64'(err), 64'(1));
    push_beat(32'h00006655, 4'b0011, 1'b1);
    #1;
    chk("err_sticky", 64'(err), 64'(1));
    chk("stall_data", 64'(sparse_tdata), 64'(32'h11CCBBAA));
    mask_tkeep = 4'b0000;
    mask_tlast = 1'b0;
    mask_tvalid = 1'b1;
    sparse_tready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(sparse_tvalid), 64'(0));
    chk("mid_rst_out", 64'({sparse_tlast, sparse_tkeep, sparse_tdata}), 64'(0));
    chk("mid_rst_err", 64'(err), 64'(0));
    chk("mid_rst_ptready", 64'(packed_tready), 64'(0));
    chk("mid_rst_mtready", 64'(mask_tready), 64'(0));
    repeat (2) @(negedge clk);
    mask_tvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    gen(3, 1'b0);
    run(0, 0, 80, 80, 80, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
